// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: classifies a RISC-V instruction, builds the
// sign-extended immediate and PC-relative target, and buffers results in a 2-entry skid.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [XLEN-1:0] target
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
        logic [XLEN-1:0] tgt;
    } entry_t;

    logic [31:0]     dec_imm32;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;

    entry_t out_q;
    entry_t skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    logic   in_ready_q;
    logic   skid_valid_d;
    logic   accept;
    logic   consume;

    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FMT_ILL;
        dec_ill   = 1'b1;
        case (instruction[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                dec_fmt   = FMT_I;
                dec_ill   = 1'b0;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_imm32 = {{20{instruction[31]}}, instruction[31:20]};
                    dec_fmt   = FMT_I;
                    dec_ill   = 1'b0;
                end
            end
            7'b0100011: begin
                dec_imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                dec_fmt   = FMT_S;
                dec_ill   = 1'b0;
            end
            7'b1100011: begin
                dec_imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                             instruction[30:25], instruction[11:8], 1'b0};
                dec_fmt   = FMT_B;
                dec_ill   = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {instruction[31:12], 12'd0};
                dec_fmt   = FMT_U;
                dec_ill   = 1'b0;
            end
            7'b1101111: begin
                dec_imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                             instruction[20], instruction[30:21], 1'b0};
                dec_fmt   = FMT_J;
                dec_ill   = 1'b0;
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
                dec_ill = 1'b0;
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_R;
                    dec_ill = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Every format sign-extends from bit 31 of the 32-bit immediate, including U on RV64.
    always_comb begin
        dec_imm       = {XLEN{dec_imm32[31]}};
        dec_imm[31:0] = dec_imm32;
    end

    always_comb begin
        dec_entry.imm = dec_imm;
        dec_entry.fmt = dec_fmt;
        dec_entry.ill = dec_ill;
        dec_entry.tgt = pc + dec_imm;
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    always_comb begin
        skid_valid_d = skid_valid_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            if (!out_valid_q || consume) begin
                // Skid only fills while OUT is stalled, so SKID has priority into OUT.
                if (skid_valid_q) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= accept;
                    if (accept) begin
                        out_q <= dec_entry;
                    end
                end
            end else if (accept) begin
                skid_q <= dec_entry;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign immediate = out_q.imm;
    assign fmt       = out_q.fmt;
    assign illegal   = out_q.ill;
    assign target    = out_q.tgt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream and are
// checked every cycle against an arithmetic decode model and a FIFO queue model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] pc32 = 32'd0;
    logic [63:0] pc64 = 64'd0;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] immediate32, target32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] immediate64, target64;
    logic [2:0]  fmt64;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .pc(pc32),
        .out_valid(out_valid32), .out_ready(out_ready),
        .immediate(immediate32), .fmt(fmt32), .illegal(illegal32), .target(target32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .pc(pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immediate(immediate64), .fmt(fmt64), .illegal(illegal64), .target(target64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm32, tgt32, imm64, tgt64;
        logic [2:0]  f32, f64;
        logic        il32, il64;
    } exp_t;

    exp_t q[$];
    bit   exp_ready = 1'b0;
    bit   last_acc = 1'b0;
    bit   rst_edge = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    function automatic void ref_dec(input logic [31:0] ins, input int xlen, input logic [63:0] pcv,
                                    output logic [63:0] imm, output logic [63:0] tgt,
                                    output logic [2:0] f, output logic il);
        longint      v;
        logic [6:0]  op;
        logic [63:0] mask;
        op = ins[6:0];
        v  = 0;
        f  = 3'd7;
        il = 1'b1;
        case (op)
            7'h03, 7'h13, 7'h67, 7'h73: begin
                v = longint'(ins >> 20);
                if (v >= 2048) v -= 4096;
                f = 3'd1; il = 1'b0;
            end
            7'h1B: if (xlen == 64) begin
                v = longint'(ins >> 20);
                if (v >= 2048) v -= 4096;
                f = 3'd1; il = 1'b0;
            end
            7'h23: begin
                v = longint'(ins >> 25) * 32 + longint'((ins >> 7) & 32'h1F);
                if (v >= 2048) v -= 4096;
                f = 3'd2; il = 1'b0;
            end
            7'h63: begin
                v = longint'(ins >> 31) * 4096 + longint'((ins >> 7) & 32'h1) * 2048
                  + longint'((ins >> 25) & 32'h3F) * 32 + longint'((ins >> 8) & 32'hF) * 2;
                if (v >= 4096) v -= 8192;
                f = 3'd3; il = 1'b0;
            end
            7'h37, 7'h17: begin
                v = longint'(ins >> 12) * 4096;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
                f = 3'd4; il = 1'b0;
            end
            7'h6F: begin
                v = longint'(ins >> 31) * 1048576 + longint'((ins >> 12) & 32'hFF) * 4096
                  + longint'((ins >> 20) & 32'h1) * 2048 + longint'((ins >> 21) & 32'h3FF) * 2;
                if (v >= 1048576) v -= 2097152;
                f = 3'd5; il = 1'b0;
            end
            7'h33: begin
                f = 3'd0; il = 1'b0;
            end
            7'h3B: if (xlen == 64) begin
                f = 3'd0; il = 1'b0;
            end
            default: ;
        endcase
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        imm  = 64'(v) & mask;
        tgt  = (pcv + 64'(v)) & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_update();
        bit   acc, cons;
        exp_t e;
        acc      = in_valid && exp_ready;
        cons     = (q.size() > 0) && out_ready;
        last_acc = 1'b0;
        rst_edge = rst;
        if (rst) begin
            q.delete();
            exp_ready = 1'b0;
        end else if (flush) begin
            q.delete();
            exp_ready = 1'b1;
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
                ref_dec(instruction, 32, {32'd0, pc32}, e.imm32, e.tgt32, e.f32, e.il32);
                ref_dec(instruction, 64, pc64, e.imm64, e.tgt64, e.f64, e.il64);
                q.push_back(e);
                last_acc = 1'b1;
            end
            exp_ready = (q.size() < 2);
        end
    endtask

    task automatic check_all();
        exp_t e;
        chk("in_ready32", 64'(in_ready32), 64'(exp_ready));
        chk("in_ready64", 64'(in_ready64), 64'(exp_ready));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            e = q[0];
            chk("imm32", 64'(immediate32), e.imm32);
            chk("tgt32", 64'(target32), e.tgt32);
            chk("fmt32", 64'(fmt32), 64'(e.f32));
            chk("ill32", 64'(illegal32), 64'(e.il32));
            chk("imm64", immediate64, e.imm64);
            chk("tgt64", target64, e.tgt64);
            chk("fmt64", 64'(fmt64), 64'(e.f64));
            chk("ill64", 64'(illegal64), 64'(e.il64));
        end else if (rst_edge) begin
            chk("rst_imm32", 64'(immediate32), 64'd0);
            chk("rst_tgt32", 64'(target32), 64'd0);
            chk("rst_fmt32", 64'(fmt32), 64'd0);
            chk("rst_ill32", 64'(illegal32), 64'd0);
            chk("rst_imm64", immediate64, 64'd0);
            chk("rst_tgt64", target64, 64'd0);
            chk("rst_fmt64", 64'(fmt64), 64'd0);
            chk("rst_ill64", 64'(illegal64), 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic send1(input logic [31:0] ins, input logic [31:0] p32, input logic [63:0] p64);
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        instruction = ins;
        pc32        = p32;
        pc64        = p64;
        step();
        in_valid    = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [0:11];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_list [0:3];
        logic [63:0] deliv [$];
        int idx;
        int dut_acc;

        @(negedge clk);
        rst = 1'b1;
        step();
        chk("reset_ready", 64'(in_ready32), 64'd0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 64'(in_ready32), 64'd1);

        send1(32'hFFF00093, 32'h100, 64'h100);
        chk("i_imm", 64'(immediate32), 64'hFFFF_FFFF);
        chk("i_fmt", 64'(fmt32), 64'd1);
        chk("i_ill", 64'(illegal32), 64'd0);
        chk("i_tgt", 64'(target32), 64'h0000_00FF);

        send1(32'hFE512E23, 32'h200, 64'h200);
        chk("s_imm", 64'(immediate32), 64'hFFFF_FFFC);
        chk("s_fmt", 64'(fmt32), 64'd2);
        send1(32'h0080006F, 32'h100, 64'h100);
        chk("j_imm", 64'(immediate32), 64'h8);
        chk("j_fmt", 64'(fmt32), 64'd5);
        chk("j_tgt", 64'(target32), 64'h108);

        send1(32'h123450B7, 32'h0, 64'h0);
        chk("u64_imm", immediate64, 64'h0000_0000_1234_5000);
        send1(32'h800000B7, 32'h0, 64'h0);
        chk("u64_neg_imm", immediate64, 64'hFFFF_FFFF_8000_0000);
        chk("u64_fmt", 64'(fmt64), 64'd4);

        send1(32'h00000000, 32'h340, 64'h1234_5678_0000_0340);
        chk("ill_flag", 64'(illegal32), 64'd1);
        chk("ill_fmt", 64'(fmt32), 64'd7);
        chk("ill_imm", 64'(immediate32), 64'd0);
        chk("ill_tgt", 64'(target32), 64'h340);
        chk("ill_tgt64", target64, 64'h1234_5678_0000_0340);
        out_ready = 1'b1;
        step();

        // Backpressure: four addi with immediates 1..4
        bp_list   = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
        out_ready = 1'b0;
        idx       = 0;
        dut_acc   = 0;
        repeat (3) begin
            in_valid    = 1'b1;
            instruction = bp_list[idx];
            pc32        = 32'h1000 + 32'(idx * 4);
            pc64        = 64'h1000 + 64'(idx * 4);
            if (in_ready32) dut_acc++;
            step();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 64'(dut_acc), 64'd2);
        chk("bp_ready_low", 64'(in_ready32), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                instruction = bp_list[idx];
                pc32        = 32'h1000 + 32'(idx * 4);
                pc64        = 64'h1000 + 64'(idx * 4);
            end
            if (out_valid32) deliv.push_back(64'(immediate32));
            step();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_deliv_count", 64'(deliv.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk("bp_deliv_order", (k < deliv.size()) ? deliv[k] : 64'hDEAD, 64'(k + 1));

        // Flush with both entries full
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h00A00093;
        repeat (3) step();
        chk("pre_flush_full", 64'(in_ready32), 64'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid32), 64'd0);
        chk("flush_ready", 64'(in_ready32), 64'd1);

        // Reset mid-stream
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'hFE512E23;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 64'(out_valid32), 64'd0);
        chk("midrst_ready", 64'(in_ready32), 64'd0);
        chk("midrst_imm", 64'(immediate32), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (!in_valid || !exp_ready || $urandom_range(0, 1) == 1) begin
                instruction = rand_inst();
                pc32        = $urandom;
                pc64        = {$urandom, $urandom};
            end
            step();
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It accepts one 32-bit RISC-V instruction and its PC per valid/ready handshake, and classifies the instruction format. For each accepted instruction it emits the sign-extended XLEN-bit immediate, the format code, an illegal flag and the PC-relative target. A two-entry skid buffer keeps `in_ready` a registered signal, so the stage can sit between fetch and register-read without a combinational ready path.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64. RV64 word opcodes are decoded only when `XLEN == 64`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; registered.
- `instruction`  in  32  raw instruction word.
- `pc`  in  XLEN  address of `instruction`.
- `out_valid`  out  1  output payload valid.
- `out_ready`  in  1  downstream accepts the payload.
- `immediate`  out  XLEN  sign-extended immediate.
- `fmt`  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- `illegal`  out  1  opcode not recognised.
- `target`  out  XLEN  `pc + immediate`, modulo 2^XLEN.

## Operation
- **Decode** is on `instruction[6:0]`. If `instruction[1:0] != 2'b11`, the instruction is illegal.
  - I: 0000011, 0010011, 1100111, 1110011, and 0011011 when XLEN=64. Immediate = sext(inst[31:20]).
  - S: 0100011. Immediate = sext({inst[31:25], inst[11:7]}).
  - B: 1100011. Immediate = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: 0110111, 0010111. Immediate = sext({inst[31:12], 12'b0}). With XLEN=64 this sign-extends from bit 31.
  - J: 1101111. Immediate = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R: 0110011, and 0111011 when XLEN=64. Immediate = 0.
  - Any other opcode: `fmt`=7, `illegal`=1, `immediate`=0, `target`=`pc`.
- **Datapath.** Decode and `target` are computed combinationally on the input side and captured into the entry. Outputs drive directly from the output register.
- **Storage.** Two entries: the output register (OUT) and the skid register (SKID), each with its own valid bit.
- **Accept.** A transfer is accepted on `in_valid && in_ready` at a clock edge.
- **Transitions per edge** (reset and flush have priority, listed first):
  - `rst` high: both valid bits cleared, all payload registers cleared to 0.
  - `flush` high (and `rst` low): both valid bits cleared; any transfer accepted in the same cycle is discarded.
  - OUT empty, or OUT consumed (`out_ready`) with SKID empty: an accepted transfer loads OUT.
  - OUT consumed and SKID full: SKID moves to OUT, and an accepted transfer loads SKID.
  - OUT full and not consumed: an accepted transfer loads SKID.
- **Ready.** `in_ready` = NOT(SKID valid) AND NOT(reset held last cycle). It is registered.
- **Ordering.** Order is strictly FIFO. No entry is dropped except by `flush` or `rst`.

## Timing
- **Reset values.** `out_valid`=0, `in_ready`=0 during the reset cycle and 1 from the first cycle after `rst` falls. `immediate`, `target` and `illegal` = 0. `fmt`=0.
- **Latency.** 1 cycle: a transfer accepted at edge N is presented with `out_valid`=1 after edge N.
- **Throughput.** 1 instruction per cycle while `out_ready`=1.
- **Stalls.** While `out_valid && !out_ready`, the payload is held stable.
- **Backpressure.** With `out_ready` held low and `in_valid` held high from empty, exactly 2 instructions are accepted and `in_ready` falls after the second.
- **Simultaneous events.**
  - `flush` and `out_ready` in the same cycle: the entry is still considered consumed by downstream, and `out_valid`=0 next cycle.
  - `rst` and `flush` together: reset behaviour applies.
- **Reset mid-operation.** Buffered entries are lost, with no partial output.

## Test plan
- **I-type, XLEN=32.** Send `FFF00093` with pc=0x100 → one cycle later `immediate`=FFFFFFFF, `fmt`=1, `illegal`=0, `target`=0x000000FF.
- **S-type and J-type.** Send `FE512E23` → `immediate`=FFFFFFFC, `fmt`=2. Then send `0080006F` with pc=0x100 → `immediate`=0x8, `fmt`=5, `target`=0x108.
- **U-type, XLEN=64.** Send `123450B7` → `immediate`=0000000012345000. Then send `800000B7` → `immediate`=FFFFFFFF80000000, `fmt`=4.
- **Illegal.** Send `00000000` → `illegal`=1, `fmt`=7, `immediate`=0, `target`=pc.
- **Backpressure.** Stream 4 distinct instructions with `out_ready`=0 for 3 cycles → 2 accepted and `in_ready`=0. Then raise `out_ready` → all 4 delivered in order with no loss or duplication.
- **Flush and reset.** With both entries full, pulse `flush` → `out_valid`=0 next cycle and `in_ready`=1. Assert `rst` mid-stream → all outputs at their reset values and `in_ready`=0 for that cycle.
